// File: rtl/pif_reg_sequencer.sv
// pif_reg_sequencer
// Buffers tagged command bytes from the I2C slave in a small FIFO and turns
// them into register writes on a req/ack bus. An address-tagged byte loads
// the address pointer; a data-tagged byte writes the payload to the register
// the pointer selects. Unknown tags and unacknowledged writes raise sticky
// error flags.
// Optional feature: define PIF_REG_AUTOINC_EN to advance the address pointer
// after every acknowledged write, so a burst of data bytes fills consecutive
// registers. Without it the pointer only moves on address bytes.
module pif_reg_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_byte,
    output logic                          rx_ready,
    output logic                          reg_wr,
    output logic [5:0]                    reg_addr,
    output logic [5:0]                    reg_wdata,
    input  logic                          reg_ack,
    input  logic                          err_clr,
    output logic                          err_tag,
    output logic                          err_timeout,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
    // Byte tags, matching the A_ADDR / D_ADDR values of pifdefs.v
    localparam logic [1:0]       TAG_ADDR  = 2'b01;
    localparam logic [1:0]       TAG_DATA  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_WRITE  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [7:0]         fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [LVL_W-1:0]   level_r;
    logic [7:0]         head_r;
    logic [5:0]         addr_ptr_r;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic               reg_wr_r;
    logic [5:0]         reg_addr_r;
    logic [5:0]         reg_wdata_r;
    logic               err_tag_r;
    logic               err_timeout_r;

    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    logic               ld_addr_s;
    logic               start_wr_s;
    logic               bad_tag_s;
    logic               ack_done_s;
    logic               tmo_done_s;

    assign full_s      = (level_r == LVL_FULL);
    assign empty_s     = (level_r == LVL_W'(0));
    // rx_ready is gated by the reset itself so no byte is taken while held
    assign rx_ready    = !sys_rst && !full_s;
    assign push_s      = rx_valid && rx_ready;

    assign reg_wr      = reg_wr_r;
    assign reg_addr    = reg_addr_r;
    assign reg_wdata   = reg_wdata_r;
    assign err_tag     = err_tag_r;
    assign err_timeout = err_timeout_r;
    assign fifo_level  = level_r;
    assign busy        = (state_r != ST_IDLE) || !empty_s;

    // FIFO storage: written on every accepted byte, never reset
    always_ff @(posedge sys_clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= rx_byte;
        end
    end

    // FIFO pointers and occupancy; push and pop together keep the level
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            level_r  <= LVL_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Sequencer state register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    state_next_s = ST_DECODE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (start_wr_s) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (ack_done_s || tmo_done_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WRITE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Per-state control strobes; an ack beats a timeout in the same cycle
    always_comb begin
        pop_s      = 1'b0;
        ld_addr_s  = 1'b0;
        start_wr_s = 1'b0;
        bad_tag_s  = 1'b0;
        ack_done_s = 1'b0;
        tmo_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                pop_s = !empty_s;
            end
            ST_DECODE: begin
                if (head_r[7:6] == TAG_ADDR) begin
                    ld_addr_s = 1'b1;
                end else if (head_r[7:6] == TAG_DATA) begin
                    start_wr_s = 1'b1;
                end else begin
                    bad_tag_s = 1'b1;
                end
            end
            ST_WRITE: begin
                if (reg_ack) begin
                    ack_done_s = 1'b1;
                end else begin
                    tmo_done_s = (tmo_cnt_r == TMO_LAST);
                end
            end
            default: begin
                pop_s = 1'b0;
            end
        endcase
    end

    // Datapath: head byte, address pointer, write request and sticky errors
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            head_r        <= 8'd0;
            addr_ptr_r    <= 6'd0;
            tmo_cnt_r     <= TMO_W'(0);
            reg_wr_r      <= 1'b0;
            reg_addr_r    <= 6'd0;
            reg_wdata_r   <= 6'd0;
            err_tag_r     <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            if (pop_s) begin
                head_r <= fifo_mem_r[rd_ptr_r];
            end

            if (ld_addr_s) begin
                addr_ptr_r <= head_r[5:0];
`ifdef PIF_REG_AUTOINC_EN
            end else if (ack_done_s) begin
                addr_ptr_r <= addr_ptr_r + 6'd1;
`endif
            end

            if (start_wr_s) begin
                reg_wr_r    <= 1'b1;
                reg_addr_r  <= addr_ptr_r;
                reg_wdata_r <= head_r[5:0];
                tmo_cnt_r   <= TMO_W'(0);
            end else if (ack_done_s || tmo_done_s) begin
                reg_wr_r    <= 1'b0;
            end else if (state_r == ST_WRITE) begin
                tmo_cnt_r   <= tmo_cnt_r + TMO_W'(1);
            end

            // A set event in the same cycle as err_clr keeps the flag set
            if (bad_tag_s) begin
                err_tag_r <= 1'b1;
            end else if (err_clr) begin
                err_tag_r <= 1'b0;
            end
            if (tmo_done_s) begin
                err_timeout_r <= 1'b1;
            end else if (err_clr) begin
                err_timeout_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pif_reg_sequencer.sv
// Scoreboard bench for pif_reg_sequencer. The stimulus side feeds a
// byte-level reference model that predicts every register write; a separate
// monitor acts as the register file, pops predictions when reg_wr rises and
// acks (or withholds the ack) according to the per-write policy.
`timescale 1ns/1ps
module tb_pif_reg_sequencer;

    localparam logic [1:0] TAG_A = 2'b01;
    localparam logic [1:0] TAG_D = 2'b10;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'd0;
    logic       rx_ready;
    logic       reg_wr;
    logic [5:0] reg_addr;
    logic [5:0] reg_wdata;
    logic       reg_ack = 1'b0;
    logic       err_clr = 1'b0;
    logic       err_tag;
    logic       err_timeout;
    logic [2:0] fifo_level;
    logic       busy;

    pif_reg_sequencer dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .rx_ready    (rx_ready),
        .reg_wr      (reg_wr),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_ack     (reg_ack),
        .err_clr     (err_clr),
        .err_tag     (err_tag),
        .err_timeout (err_timeout),
        .fifo_level  (fifo_level),
        .busy        (busy)
    );

    always #25 sys_clk = ~sys_clk;

    // Expected write: target, data and how many cycles the register file
    // waits before acking (-1 means never ack, so the write must time out)
    typedef struct {
        logic [5:0] addr;
        logic [5:0] data;
        int         delay;
    } wr_t;

    wr_t        exp_q[$];
    logic [5:0] m_ptr   = 6'd0;
    int         exp_tag = 0;
    int         exp_tmo = 0;
    int         checks  = 0;
    int         errors  = 0;

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: consume one accepted byte
    task automatic model_accept(input logic [7:0] b, input int dly);
        wr_t w;
        if (b[7:6] == TAG_A) begin
            m_ptr = b[5:0];
        end else if (b[7:6] == TAG_D) begin
            w.addr = m_ptr;
            w.data = b[5:0];
            w.delay = dly;
            exp_q.push_back(w);
`ifdef PIF_REG_AUTOINC_EN
            if (dly >= 0) m_ptr = m_ptr + 6'd1;
`endif
        end else begin
            exp_tag = 1;
        end
    endtask

    task automatic push(input logic [7:0] b, input int dly);
        int n = 0;
        @(negedge sys_clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        if (!rx_ready) begin
            check_int("push_ready", rx_ready, 1);
        end else begin
            @(posedge sys_clk);
            model_accept(b, dly);
        end
        #1 rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge sys_clk);
        while (busy && n < 600) begin
            @(negedge sys_clk);
            n++;
        end
        @(negedge sys_clk);
        check_int("drain_busy", busy, 0);
        check_int("drain_queue", exp_q.size(), 0);
        check_int("err_tag", err_tag, exp_tag);
        check_int("err_timeout", err_timeout, exp_tmo);
    endtask

    task automatic clear_errs();
        @(negedge sys_clk);
        err_clr = 1'b1;
        @(negedge sys_clk);
        err_clr = 1'b0;
        check_int("clr_tag", err_tag, 0);
        check_int("clr_timeout", err_timeout, 0);
        exp_tag = 0;
        exp_tmo = 0;
    endtask

    // Monitor / register-file responder
    initial begin
        wr_t cur;
        int  wr_seen  = 0;
        int  hi_cnt   = 0;
        int  ack_sent = 0;
        cur.addr = 6'd0;
        cur.data = 6'd0;
        cur.delay = 0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst) begin
                wr_seen  = 0;
                ack_sent = 0;
                reg_ack  = 1'b0;
                continue;
            end
            if (reg_ack) begin
                reg_ack  = 1'b0;
                ack_sent = 1;
            end
            if (wr_seen != 0 && ack_sent != 0) begin
                check_int("ack_drop", reg_wr, 0);
                check_int("ack_no_tmo", err_timeout, exp_tmo);
                wr_seen = 0;
            end else if (wr_seen != 0 && !reg_wr) begin
                check_int("tmo_len", hi_cnt, 64);
                check_int("tmo_flag", err_timeout, 1);
                exp_tmo = 1;
                wr_seen = 0;
            end else if (wr_seen != 0) begin
                hi_cnt++;
            end else if (reg_wr) begin
                check_int("wr_expected", exp_q.size() > 0 ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    check_int("wr_addr", reg_addr, cur.addr);
                    check_int("wr_data", reg_wdata, cur.data);
                end else begin
                    cur.delay = 0;
                end
                wr_seen  = 1;
                hi_cnt   = 1;
                ack_sent = 0;
            end
            if (wr_seen != 0 && ack_sent == 0 && cur.delay >= 0 && hi_cnt == cur.delay + 1) begin
                reg_ack = 1'b1;
            end
        end
    end

    initial begin
        int n;
        logic [1:0] tg;
        int dly;

        // Reset state
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check_int("rst_rx_ready", rx_ready, 0);
        check_int("rst_reg_wr", reg_wr, 0);
        check_int("rst_level", fifo_level, 0);
        check_int("rst_busy", busy, 0);
        check_int("rst_err_tag", err_tag, 0);
        check_int("rst_err_tmo", err_timeout, 0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check_int("rel_rx_ready", rx_ready, 1);

        // Single addressed write, then a burst
        push({TAG_A, 6'd2}, 0);
        push({TAG_D, 6'd1}, 1);
        wait_idle();
        push({TAG_A, 6'd2}, 0);
        push({TAG_D, 6'd1}, 0);
        push({TAG_D, 6'd5}, 2);
        push({TAG_D, 6'd7}, 1);
        wait_idle();

        // Address wrap at 63
        push({TAG_A, 6'd63}, 0);
        push({TAG_D, 6'd9}, 0);
        push({TAG_D, 6'd4}, 3);
        wait_idle();

        // Ack arriving on the last timeout cycle wins
        push({TAG_A, 6'd20}, 0);
        push({TAG_D, 6'd33}, 63);
        wait_idle();

        // Backpressure with a stalled write, then timeout and drain
        push({TAG_D, 6'd11}, -1);
        push({TAG_A, 6'd5}, 0);
        push({TAG_D, 6'd12}, 1);
        push({TAG_D, 6'd13}, 0);
        push({TAG_A, 6'd9}, 0);
        @(negedge sys_clk);
        check_int("full_level", fifo_level, 4);
        check_int("full_ready", rx_ready, 0);
        check_int("full_stalled", reg_wr, 1);
        push({TAG_D, 6'd14}, 2);
        wait_idle();
        clear_errs();

        // Unknown tag, then clear coincident with a new bad tag
        push(8'hC5, 0);
        wait_idle();
        clear_errs();
        push(8'h07, 0);
        @(posedge sys_clk);
        #1 err_clr = 1'b1;
        @(posedge sys_clk);
        #1 err_clr = 1'b0;
        check_int("clr_vs_set", err_tag, 1);
        wait_idle();
        clear_errs();

        // Randomized batches
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 15; i++) begin
                n = $urandom_range(0, 99);
                if (n < 35)      tg = TAG_A;
                else if (n < 85) tg = TAG_D;
                else             tg = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
                dly = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 4));
                push({tg, 6'($urandom_range(0, 63))}, dly);
                repeat ($urandom_range(0, 3)) @(negedge sys_clk);
            end
            wait_idle();
            clear_errs();
        end

        // Reset while a write is outstanding
        push({TAG_A, 6'd10}, 0);
        push({TAG_D, 6'd3}, -1);
        n = 0;
        while (!reg_wr && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        check_int("pre_rst_wr", reg_wr, 1);
        @(posedge sys_clk);
        #5 sys_rst = 1'b1;
        #1;
        check_int("async_wr", reg_wr, 0);
        check_int("async_level", fifo_level, 0);
        check_int("async_busy", busy, 0);
        check_int("async_ready", rx_ready, 0);
        exp_q.delete();
        m_ptr   = 6'd0;
        exp_tag = 0;
        exp_tmo = 0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        // Pointer must be back at 0: data without an address byte hits reg 0
        push({TAG_D, 6'd7}, 0);
        push({TAG_A, 6'd2}, 0);
        push({TAG_D, 6'd1}, 1);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
